// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode encodings, sequencer state encoding and opcode-class decode
// helpers for the ALU operation sequencer and its neighbours.
package alu_op_sequencer_pkg;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOT = 4'd6;
  localparam logic [3:0] ALU_LRS = 4'd7;
  localparam logic [3:0] ALU_ARS = 4'd8;
  localparam logic [3:0] ALU_RR  = 4'd9;
  localparam logic [3:0] ALU_LLS = 4'd10;
  localparam logic [3:0] ALU_ALS = 4'd11;
  localparam logic [3:0] ALU_RL  = 4'd12;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_EXEC    = 3'd1,
    SEQ_SHIFT   = 3'd2,
    SEQ_WIDE_LO = 3'd3,
    SEQ_WIDE_HI = 3'd4,
    SEQ_DONE    = 3'd5
  } seq_state_t;

  // Opcodes the ALU only implements as single-bit steps.
  function automatic logic is_shift_op(input logic [3:0] op);
    logic hit;
    case (op)
      ALU_LRS, ALU_ARS, ALU_RR, ALU_LLS, ALU_ALS, ALU_RL: hit = 1'b1;
      default:                                           hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    logic hit;
    case (op)
      ALU_ADD, ALU_SUB: hit = 1'b1;
      default:          hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of the 16-bit ALU: repeats 1-bit shift ops
// for N-bit shifts/rotates and chains two passes for 32-bit ADD/SUB.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_cin,
  input  logic             req_wide,
  input  logic [CNT_W-1:0] req_count,
  output logic [15:0]      alu_input1,
  output logic [15:0]      alu_input2,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic [15:0]      alu_result,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_cout
);

  seq_state_t       state_r, next_state_s;
  logic [3:0]       op_r;
  logic [31:0]      a_r, b_r;
  logic             cin_r, carry_r;
  logic [15:0]      work_r, lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_ready_r, rsp_valid_r, rsp_cout_r;
  logic [31:0]      rsp_result_r;
  logic             accept_s;

  assign accept_s   = req_valid && req_ready_r;
  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_cout   = rsp_cout_r;

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SEQ_IDLE: begin
        if (accept_s) begin
          if (is_shift_op(req_op)) begin
            next_state_s = (req_count == '0) ? SEQ_DONE : SEQ_SHIFT;
          end else if (is_arith_op(req_op) && req_wide) begin
            next_state_s = SEQ_WIDE_LO;
          end else begin
            next_state_s = SEQ_EXEC;
          end
        end else begin
          next_state_s = SEQ_IDLE;
        end
      end
      SEQ_EXEC:    next_state_s = SEQ_DONE;
      SEQ_SHIFT: begin
        if (cnt_r == CNT_W'(1)) begin
          next_state_s = SEQ_DONE;
        end else begin
          next_state_s = SEQ_SHIFT;
        end
      end
      SEQ_WIDE_LO: next_state_s = SEQ_WIDE_HI;
      SEQ_WIDE_HI: next_state_s = SEQ_DONE;
      SEQ_DONE: begin
        if (rsp_ready) begin
          next_state_s = SEQ_IDLE;
        end else begin
          next_state_s = SEQ_DONE;
        end
      end
      default:     next_state_s = SEQ_IDLE;
    endcase
  end

  // ALU drive; quiet (all zero) in every non-computing state and during reset.
  always_comb begin
    alu_op     = 4'd0;
    alu_input1 = 16'h0000;
    alu_input2 = 16'h0000;
    alu_cin    = 1'b0;
    if (reset) begin
      alu_op = 4'd0;
    end else begin
      case (state_r)
        SEQ_EXEC, SEQ_WIDE_LO: begin
          alu_op     = op_r;
          alu_input1 = a_r[15:0];
          alu_input2 = b_r[15:0];
          alu_cin    = cin_r;
        end
        SEQ_SHIFT: begin
          alu_op     = op_r;
          alu_input1 = work_r;
        end
        SEQ_WIDE_HI: begin
          alu_op     = op_r;
          alu_input1 = a_r[31:16];
          alu_input2 = b_r[31:16];
          alu_cin    = carry_r;
        end
        default: alu_op = 4'd0;
      endcase
    end
  end

  // State, operand file and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= SEQ_IDLE;
      op_r         <= 4'd0;
      a_r          <= 32'h0;
      b_r          <= 32'h0;
      cin_r        <= 1'b0;
      carry_r      <= 1'b0;
      work_r       <= 16'h0;
      lo_r         <= 16'h0;
      cnt_r        <= '0;
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 32'h0;
      rsp_cout_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_ready_r <= (next_state_s == SEQ_IDLE);
      case (state_r)
        SEQ_IDLE: begin
          if (accept_s) begin
            op_r   <= req_op;
            a_r    <= req_a;
            b_r    <= req_b;
            cin_r  <= req_cin;
            cnt_r  <= req_count;
            work_r <= req_a[15:0];
            // A zero-count shift completes without touching the ALU.
            if (is_shift_op(req_op) && (req_count == '0)) begin
              rsp_valid_r  <= 1'b1;
              rsp_result_r <= {16'h0000, req_a[15:0]};
              rsp_cout_r   <= 1'b0;
            end
          end
        end
        SEQ_EXEC: begin
          rsp_valid_r  <= 1'b1;
          rsp_result_r <= {16'h0000, alu_result};
          rsp_cout_r   <= is_arith_op(op_r) & alu_cout;
        end
        SEQ_SHIFT: begin
          work_r <= alu_result;
          cnt_r  <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= {16'h0000, alu_result};
            rsp_cout_r   <= 1'b0;
          end
        end
        SEQ_WIDE_LO: begin
          lo_r    <= alu_result;
          carry_r <= alu_cout;
        end
        SEQ_WIDE_HI: begin
          rsp_valid_r  <= 1'b1;
          rsp_result_r <= {alu_result, lo_r};
          rsp_cout_r   <= alu_cout;
        end
        SEQ_DONE: begin
          if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'h0;
            rsp_cout_r   <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: behavioural 16-bit ALU next to the sequencer, directed
// scenarios plus randomized requests checked against a closed-form model.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_cin, req_wide;
  logic [3:0]  req_op, req_count;
  logic [31:0] req_a, req_b;
  logic [15:0] alu_input1, alu_input2, alu_result;
  logic        alu_cin, alu_cout;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_cout;
  logic [31:0] rsp_result;
  logic [16:0] alu_s17;

  int checks = 0;
  int failures = 0;
  int pass_total = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_wide(req_wide),
    .req_count(req_count),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout)
  );

  // Behavioural ALU; non-arithmetic ops drive junk on Cout that must be ignored.
  always_comb begin
    alu_s17    = 17'h0;
    alu_result = 16'h0;
    alu_cout   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_s17 = {1'b0, alu_input1} + {1'b0, alu_input2} + {16'h0, alu_cin};
        alu_result = alu_s17[15:0]; alu_cout = alu_s17[16];
      end
      ALU_SUB: begin
        alu_s17 = {1'b0, alu_input1} - {1'b0, alu_input2} - {16'h0, alu_cin};
        alu_result = alu_s17[15:0]; alu_cout = alu_s17[16];
      end
      ALU_AND: begin alu_result = alu_input1 & alu_input2; alu_cout = ^alu_input1; end
      ALU_OR:  begin alu_result = alu_input1 | alu_input2; alu_cout = ^alu_input1; end
      ALU_XOR: begin alu_result = alu_input1 ^ alu_input2; alu_cout = ^alu_input1; end
      ALU_NOT: begin alu_result = ~alu_input1;             alu_cout = ^alu_input1; end
      ALU_LRS: begin alu_result = {1'b0, alu_input1[15:1]};          alu_cout = alu_input1[0]; end
      ALU_ARS: begin alu_result = {alu_input1[15], alu_input1[15:1]}; alu_cout = alu_input1[0]; end
      ALU_RR:  begin alu_result = {alu_input1[0], alu_input1[15:1]};  alu_cout = alu_input1[0]; end
      ALU_LLS: begin alu_result = {alu_input1[14:0], 1'b0};           alu_cout = alu_input1[15]; end
      ALU_ALS: begin alu_result = {alu_input1[14:0], 1'b0};           alu_cout = alu_input1[15]; end
      ALU_RL:  begin alu_result = {alu_input1[14:0], alu_input1[15]}; alu_cout = alu_input1[15]; end
      default: begin alu_result = 16'h0; alu_cout = 1'b0; end
    endcase
  end

  always @(posedge clk) if (alu_op != 4'd0) pass_total = pass_total + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: whole-request result from closed-form arithmetic.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic wide, input logic [3:0] cnt,
                                    output logic [31:0] res, output logic co, output int lat, output int passes);
    logic [32:0] w;
    logic [16:0] n;
    logic [31:0] dbl;
    logic [15:0] a16, r16;
    logic signed [15:0] s16;
    int sh;
    sh = int'(cnt); a16 = a[15:0]; dbl = {a16, a16}; r16 = 16'h0;
    res = 32'h0; co = 1'b0; lat = 2; passes = (op == ALU_NOP) ? 0 : 1;
    case (op)
      ALU_ADD, ALU_SUB: begin
        if (wide) begin
          w = (op == ALU_ADD) ? ({1'b0, a} + {1'b0, b} + {32'h0, cin}) : ({1'b0, a} - {1'b0, b} - {32'h0, cin});
          res = w[31:0]; co = w[32]; lat = 3; passes = 2;
        end else begin
          n = (op == ALU_ADD) ? ({1'b0, a16} + {1'b0, b[15:0]} + {16'h0, cin}) : ({1'b0, a16} - {1'b0, b[15:0]} - {16'h0, cin});
          res = {16'h0, n[15:0]}; co = n[16];
        end
      end
      ALU_AND: res = {16'h0, a16 & b[15:0]};
      ALU_OR:  res = {16'h0, a16 | b[15:0]};
      ALU_XOR: res = {16'h0, a16 ^ b[15:0]};
      ALU_NOT: res = {16'h0, ~a16};
      ALU_LRS: begin r16 = a16 >> sh; res = {16'h0, r16}; end
      ALU_ARS: begin s16 = $signed(a16) >>> sh; res = {16'h0, s16}; end
      ALU_LLS, ALU_ALS: begin r16 = a16 << sh; res = {16'h0, r16}; end
      ALU_RR: begin dbl = dbl >> sh; res = {16'h0, dbl[15:0]}; end
      ALU_RL: begin dbl = dbl << sh; res = {16'h0, dbl[31:16]}; end
      default: res = 32'h0;
    endcase
    if (op inside {ALU_LRS, ALU_ARS, ALU_RR, ALU_LLS, ALU_ALS, ALU_RL}) begin
      lat = 1 + sh; passes = sh;
    end
  endfunction

  // Drive one request and collect observations; called and returns at a negedge.
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic wide, input logic [3:0] cnt, input int hold,
                        output logic [31:0] res, output logic co, output int lat, output int passes,
                        output int unstable);
    int p0;
    int w;
    logic seen;
    lat = -1; passes = -1; unstable = 0; res = 32'h0; co = 1'b0; seen = 1'b0;
    w = 0;
    while (!req_ready && w < 30) begin @(negedge clk); w++; end
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_wide = wide; req_count = cnt;
    req_valid = 1'b1;
    p0 = pass_total;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_count = 4'($urandom);
    req_cin = 1'($urandom); req_wide = 1'($urandom);
    @(negedge clk);
    for (int e = 0; e < 40; e++) begin
      if (!seen && rsp_valid) begin seen = 1'b1; lat = e + 1; end
      if (!seen) @(negedge clk);
    end
    if (seen) begin
      res = rsp_result; co = rsp_cout; passes = pass_total - p0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (rsp_result !== res || rsp_cout !== co || rsp_valid !== 1'b1 || req_ready !== 1'b0) unstable++;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_op = 4'd0; req_a = 32'h0;
    req_b = 32'h0; req_cin = 1'b0; req_wide = 1'b0; req_count = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_cout, alu_cin} !== 4'b0000 || rsp_result !== 32'h0 || alu_op !== 4'd0
        || alu_input1 !== 16'h0 || alu_input2 !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b result=%h op=%h want all zero", req_ready, rsp_valid, rsp_result, alu_op);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 4'd0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b op=%h want ready=1 valid=0 op=0", req_ready, rsp_valid, alu_op);
    end
  endtask

  task automatic test_narrow_add();
    logic [31:0] r; logic c; int l, p, u;
    do_txn(ALU_ADD, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 4'd0, 0, r, c, l, p, u);
    checks++; if (r !== 32'h0000_1235) begin failures++; $display("FAIL add_result got=%h want=%h", r, 32'h0000_1235); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL add_cout got=%b want=0", c); end
    checks++; if (l !== 2) begin failures++; $display("FAIL add_latency got=%0d want=2", l); end
    checks++; if (p !== 1) begin failures++; $display("FAIL add_passes got=%0d want=1", p); end
  endtask

  task automatic test_wide_arith();
    logic [31:0] r; logic c; int l, p, u;
    do_txn(ALU_ADD, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'd0, 0, r, c, l, p, u);
    checks++; if (r !== 32'h0002_0000) begin failures++; $display("FAIL wide_add_result got=%h want=%h", r, 32'h0002_0000); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL wide_add_cout got=%b want=0", c); end
    checks++; if (l !== 3 || p !== 2) begin failures++; $display("FAIL wide_add_timing got lat=%0d passes=%0d want 3/2", l, p); end
    do_txn(ALU_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd0, 0, r, c, l, p, u);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wide_sub_result got=%h want=%h", r, 32'hFFFF_FFFF); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL wide_sub_cout got=%b want=1", c); end
  endtask

  task automatic test_shifts();
    logic [31:0] r; logic c; int l, p, u;
    do_txn(ALU_ARS, 32'h0000_8000, 32'h0, 1'b0, 1'b0, 4'd4, 0, r, c, l, p, u);
    checks++; if (r !== 32'h0000_F800) begin failures++; $display("FAIL ars_result got=%h want=%h", r, 32'h0000_F800); end
    checks++; if (p !== 4 || l !== 5) begin failures++; $display("FAIL ars_timing got passes=%0d lat=%0d want 4/5", p, l); end
    do_txn(ALU_RL, 32'h0000_8001, 32'h0, 1'b0, 1'b0, 4'd3, 0, r, c, l, p, u);
    checks++; if (r !== 32'h0000_000C || c !== 1'b0) begin failures++; $display("FAIL rl_result got=%h cout=%b want=0000000c/0", r, c); end
  endtask

  task automatic test_zero_count();
    logic [31:0] r; logic c; int l, p, u;
    do_txn(ALU_LLS, 32'hABCD_00F0, 32'h0, 1'b0, 1'b0, 4'd0, 0, r, c, l, p, u);
    checks++; if (r !== 32'h0000_00F0) begin failures++; $display("FAIL zero_count_result got=%h want=%h", r, 32'h0000_00F0); end
    checks++; if (l !== 1 || p !== 0) begin failures++; $display("FAIL zero_count_timing got lat=%0d passes=%0d want 1/0", l, p); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic c; int l, p, u;
    do_txn(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 4'd0, 5, r, c, l, p, u);
    checks++; if (u !== 0) begin failures++; $display("FAIL backpressure_stable got unstable_cycles=%0d want=0", u); end
    checks++; if (r !== 32'h0000_0FF0 || c !== 1'b0) begin failures++; $display("FAIL backpressure_result got=%h/%b want=00000ff0/0", r, c); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rsp_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    req_op = ALU_ARS; req_a = 32'h0000_8000; req_count = 4'd10; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (alu_op !== ALU_ARS) begin failures++; $display("FAIL mid_shift_active got op=%h want=%h", alu_op, ALU_ARS); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || alu_op !== 4'd0) begin
      failures++; $display("FAIL mid_reset got valid=%b ready=%b op=%h want 0/0/0", rsp_valid, req_ready, alu_op);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", req_ready); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid !== 1'b0 || alu_op !== 4'd0) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_reset_dropped got busy_cycles=%0d want=0", seen); end
  endtask

  task automatic test_random();
    logic [31:0] r, er, a, b; logic c, ec, cin, wide; int l, p, u, el, ep;
    logic [3:0] op, cnt;
    for (int t = 0; t < 40; t++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
      cin = 1'($urandom); wide = 1'($urandom); cnt = 4'($urandom_range(0, 15));
      ref_model(op, a, b, cin, wide, cnt, er, ec, el, ep);
      do_txn(op, a, b, cin, wide, cnt, t % 3, r, c, l, p, u);
      checks++; if (r !== er) begin failures++; $display("FAIL rand_result op=%0d got=%h want=%h", op, r, er); end
      checks++; if (c !== ec) begin failures++; $display("FAIL rand_cout op=%0d got=%b want=%b", op, c, ec); end
      checks++; if (l !== el) begin failures++; $display("FAIL rand_latency op=%0d got=%0d want=%0d", op, l, el); end
      checks++; if (p !== ep || u !== 0) begin failures++; $display("FAIL rand_passes op=%0d got=%0d/%0d want=%0d/0", op, p, u, ep); end
    end
  endtask

  initial begin
    test_reset();
    test_narrow_add();
    test_wide_arith();
    test_shifts();
    test_zero_count();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
